// File: rtl/ucaspian_pkg.sv
// ---------------------------------------------------------------------------
// ucaspian_pkg
// Shared definitions for the uCaspian axon fanout engine: the FSM state
// encoding, the widths of the table entry fields, the table depths and a
// helper that widens a synapse weight into a neuron charge.
// ---------------------------------------------------------------------------
package ucaspian_pkg;

    localparam int NUM_AXONS    = 256;
    localparam int NUM_SYNAPSES = 256;

    // Both tables are 256 x 16; each entry packs two 8-bit fields.
    localparam int TBL_ADDR_W = 8;
    localparam int ENTRY_W    = 16;
    localparam int FIELD_W    = 8;
    localparam int CHARGE_W   = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        FETCH  = 2'd2,
        EMIT   = 2'd3
    } fanout_state_e;

    // Weights are signed 8-bit; charges leaving the block are signed 16-bit.
    function automatic logic signed [CHARGE_W-1:0] sext_weight(input logic [FIELD_W-1:0] w);
        return {{(CHARGE_W-FIELD_W){w[FIELD_W-1]}}, w};
    endfunction

endpackage

// File: rtl/ucaspian_axon_fanout_if.sv
// ---------------------------------------------------------------------------
// ucaspian_axon_fanout_if
// Bundles the two handshaked streams of the fanout engine:
//   axon_addr/axon_vld/axon_rdy            fire events into the engine
//   neuron_addr/neuron_charge/neuron_vld/
//   neuron_rdy                             charge events out of the engine
// modport master : the environment (issues fire events, sinks charges)
// modport slave  : the fanout engine
// ---------------------------------------------------------------------------
interface ucaspian_axon_fanout_if;
    import ucaspian_pkg::*;

    logic        [TBL_ADDR_W-1:0] axon_addr;
    logic                         axon_vld;
    logic                         axon_rdy;

    logic        [TBL_ADDR_W-1:0] neuron_addr;
    logic signed [CHARGE_W-1:0]   neuron_charge;
    logic                         neuron_vld;
    logic                         neuron_rdy;

    modport master (
        output axon_addr, axon_vld, neuron_rdy,
        input  axon_rdy, neuron_addr, neuron_charge, neuron_vld
    );

    modport slave (
        input  axon_addr, axon_vld, neuron_rdy,
        output axon_rdy, neuron_addr, neuron_charge, neuron_vld
    );

endinterface

// File: rtl/dp_ram_16x256.sv
// ---------------------------------------------------------------------------
// dp_ram_16x256
// 256-entry, 16-bit simple dual-port RAM: one write port, one read port,
// both on the rising edge of clk. Read data is registered, so it appears the
// cycle after rd_addr is presented. Contents are never reset.
// Ports:
//   clk      clock
//   wr_en    write strobe
//   wr_addr  write address
//   wr_data  write data
//   rd_addr  read address (sampled every cycle)
//   rd_data  registered read data
// ---------------------------------------------------------------------------
module dp_ram_16x256 (
    input  logic        clk,
    input  logic        wr_en,
    input  logic [7:0]  wr_addr,
    input  logic [15:0] wr_data,
    input  logic [7:0]  rd_addr,
    output logic [15:0] rd_data
);

    logic [15:0] mem [0:255];
    logic [15:0] rd_data_q;

    // Storage array plus registered read; no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/ucaspian_axon_fanout.sv
// ---------------------------------------------------------------------------
// ucaspian_axon_fanout
// Turns each accepted axon fire event into a burst of charge events: the
// axon table gives {start, count} and the synapse table entries
// start .. start+count-1 (wrapping mod 256) each give {target, weight}.
// Ports:
//   clk, reset         clock; asynchronous active-high reset
//   enable             allows new fire events to be accepted
//   cfg_we/cfg_sel     table write strobe; 0 = axon table, 1 = synapse table
//   cfg_addr/cfg_data  table write address/data
//   step_done          registered: no fanout work pending and no fire waiting
//   fire_if            fire-event input and charge-event output streams
// ---------------------------------------------------------------------------
module ucaspian_axon_fanout
    import ucaspian_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  cfg_we,
    input  logic                  cfg_sel,
    input  logic [TBL_ADDR_W-1:0] cfg_addr,
    input  logic [ENTRY_W-1:0]    cfg_data,
    output logic                  step_done,
    ucaspian_axon_fanout_if.slave fire_if
);

    fanout_state_e               state_q, state_d;
    logic [TBL_ADDR_W-1:0]       ptr_q, ptr_d;
    logic [FIELD_W-1:0]          remaining_q, remaining_d;
    logic [TBL_ADDR_W-1:0]       neuron_addr_q, neuron_addr_d;
    logic signed [CHARGE_W-1:0]  neuron_charge_q, neuron_charge_d;
    logic                        neuron_vld_q, neuron_vld_d;
    logic                        step_done_q, step_done_d;

    logic [ENTRY_W-1:0]          axon_rd_data;
    logic [ENTRY_W-1:0]          syn_rd_data;
    logic [TBL_ADDR_W-1:0]       syn_rd_addr;
    logic                        accept;
    logic                        handshake;

    logic [FIELD_W-1:0]          axon_start;
    logic [FIELD_W-1:0]          axon_count;
    logic [FIELD_W-1:0]          syn_target;
    logic [FIELD_W-1:0]          syn_weight;

    assign axon_start = axon_rd_data[ENTRY_W-1:FIELD_W];
    assign axon_count = axon_rd_data[FIELD_W-1:0];
    assign syn_target = syn_rd_data[ENTRY_W-1:FIELD_W];
    assign syn_weight = syn_rd_data[FIELD_W-1:0];

    assign fire_if.axon_rdy = (state_q == IDLE) && enable;
    assign accept           = fire_if.axon_vld && fire_if.axon_rdy;
    assign handshake        = neuron_vld_q && fire_if.neuron_rdy;

    // The axon table is addressed straight from the fire input so the RAM's
    // read register captures the event on the accepting edge; its data is
    // therefore valid in LOOKUP without a separate address register.
    dp_ram_16x256 u_axon_tbl (
        .clk     (clk),
        .wr_en   (cfg_we && !cfg_sel),
        .wr_addr (cfg_addr),
        .wr_data (cfg_data),
        .rd_addr (fire_if.axon_addr),
        .rd_data (axon_rd_data)
    );

    dp_ram_16x256 u_syn_tbl (
        .clk     (clk),
        .wr_en   (cfg_we && cfg_sel),
        .wr_addr (cfg_addr),
        .wr_data (cfg_data),
        .rd_addr (syn_rd_addr),
        .rd_data (syn_rd_data)
    );

    // Next-state logic. The synapse read address is steered so the entry
    // needed in FETCH is already being read on the edge that enters FETCH:
    // the start field out of LOOKUP, or ptr+1 on an EMIT handshake.
    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        remaining_d     = remaining_q;
        neuron_addr_d   = neuron_addr_q;
        neuron_charge_d = neuron_charge_q;
        neuron_vld_d    = neuron_vld_q;
        syn_rd_addr     = ptr_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = LOOKUP;
                end
            end

            LOOKUP: begin
                if (axon_count == '0) begin
                    state_d = IDLE;
                end else begin
                    ptr_d       = axon_start;
                    remaining_d = axon_count;
                    syn_rd_addr = axon_start;
                    state_d     = FETCH;
                end
            end

            FETCH: begin
                neuron_addr_d   = syn_target;
                neuron_charge_d = sext_weight(syn_weight);
                neuron_vld_d    = 1'b1;
                state_d         = EMIT;
            end

            EMIT: begin
                if (handshake) begin
                    neuron_vld_d = 1'b0;
                    remaining_d  = remaining_q - 1'b1;
                    ptr_d        = ptr_q + 1'b1;
                    syn_rd_addr  = ptr_q + 1'b1;
                    state_d      = (remaining_q == 8'd1) ? IDLE : FETCH;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        step_done_d = (state_d == IDLE) && !fire_if.axon_vld;
    end

    // State and output registers; reset clears everything except the tables.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            ptr_q           <= '0;
            remaining_q     <= '0;
            neuron_addr_q   <= '0;
            neuron_charge_q <= '0;
            neuron_vld_q    <= 1'b0;
            step_done_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            remaining_q     <= remaining_d;
            neuron_addr_q   <= neuron_addr_d;
            neuron_charge_q <= neuron_charge_d;
            neuron_vld_q    <= neuron_vld_d;
            step_done_q     <= step_done_d;
        end
    end

    assign fire_if.neuron_addr   = neuron_addr_q;
    assign fire_if.neuron_charge = neuron_charge_q;
    assign fire_if.neuron_vld    = neuron_vld_q;
    assign step_done             = step_done_q;

endmodule
